// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stage sequencing and hazard control for the 5-stage
// pipeline_cpu (IF/ID/EXE/MEM/WB). It owns the per-stage valid bits, the
// allow-in/over handshake, the pipeline-register latch enables, load-use
// stall detection and ID operand forwarding selection.
// Optional performance counters are built when PIPELINE_CTRL_PERF_EN is
// defined; otherwise stall_cnt/flush_cnt are tied to zero.
module pipeline_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IF_over,
  input  logic              ID_over,
  input  logic              EXE_over,
  input  logic              MEM_over,
  input  logic              WB_over,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_use_rs,
  input  logic              ID_use_rt,
  input  logic [REG_AW-1:0] EXE_wdest,
  input  logic [REG_AW-1:0] MEM_wdest,
  input  logic [REG_AW-1:0] WB_wdest,
  input  logic              EXE_load,
  input  logic              cancel,
  output logic              IF_valid,
  output logic              ID_valid,
  output logic              EXE_valid,
  output logic              MEM_valid,
  output logic              WB_valid,
  output logic              next_fetch,
  output logic              IF_to_ID,
  output logic              ID_to_EXE,
  output logic              EXE_to_MEM,
  output logic              MEM_to_WB,
  output logic              load_use_stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Stage occupancy
  logic if_valid_r;
  logic id_valid_r;
  logic exe_valid_r;
  logic mem_valid_r;
  logic wb_valid_r;

  // Handshake and control terms
  logic go_s;
  logic if_q_s;
  logic id_q_s;
  logic exe_q_s;
  logic mem_q_s;
  logic id_allow_in_s;
  logic exe_allow_in_s;
  logic mem_allow_in_s;
  logic wb_allow_in_s;
  logic if_to_id_s;
  logic id_to_exe_s;
  logic exe_to_mem_s;
  logic mem_to_wb_s;
  logic next_fetch_s;
  logic load_use_stall_s;
  logic [1:0] fwd_rs_sel_s;
  logic [1:0] fwd_rt_sel_s;

  // Forwarding source for one ID operand; EXE beats MEM beats WB.
  // A load in EXE has no result yet, so the caller clears exe_ok for it.
  function automatic logic [1:0] fwd_select(
    input logic              use_op,
    input logic [REG_AW-1:0] op,
    input logic              exe_ok,
    input logic [REG_AW-1:0] exe_d,
    input logic              mem_ok,
    input logic [REG_AW-1:0] mem_d,
    input logic              wb_ok,
    input logic [REG_AW-1:0] wb_d
  );
    logic [1:0] sel;
    if (!use_op) begin
      sel = 2'b00;
    end else if (exe_ok && (exe_d != {REG_AW{1'b0}}) && (exe_d == op)) begin
      sel = 2'b01;
    end else if (mem_ok && (mem_d != {REG_AW{1'b0}}) && (mem_d == op)) begin
      sel = 2'b10;
    end else if (wb_ok && (wb_d != {REG_AW{1'b0}}) && (wb_d == op)) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Handshake chain: back-pressure ripples from WB toward IF in one cycle;
  // reset and cancel suppress every transfer.
  always_comb begin
    go_s = !reset && !cancel;
    load_use_stall_s = id_valid_r & exe_valid_r & EXE_load &
                       (EXE_wdest != {REG_AW{1'b0}}) &
                       ((ID_use_rs & (ID_rs == EXE_wdest)) |
                        (ID_use_rt & (ID_rt == EXE_wdest)));
    if_q_s  = if_valid_r  & IF_over;
    id_q_s  = id_valid_r  & ID_over & ~load_use_stall_s;
    exe_q_s = exe_valid_r & EXE_over;
    mem_q_s = mem_valid_r & MEM_over;
    wb_allow_in_s  = ~wb_valid_r  | WB_over;
    mem_allow_in_s = ~mem_valid_r | (mem_q_s & wb_allow_in_s);
    exe_allow_in_s = ~exe_valid_r | (exe_q_s & mem_allow_in_s);
    id_allow_in_s  = ~id_valid_r  | (id_q_s  & exe_allow_in_s);
    if_to_id_s   = if_q_s  & id_allow_in_s  & go_s;
    id_to_exe_s  = id_q_s  & exe_allow_in_s & go_s;
    exe_to_mem_s = exe_q_s & mem_allow_in_s & go_s;
    mem_to_wb_s  = mem_q_s & wb_allow_in_s  & go_s;
    next_fetch_s = (~if_valid_r & ~reset) | if_to_id_s;
  end

  // Operand forwarding selection for rs and rt.
  always_comb begin
    fwd_rs_sel_s = fwd_select(ID_use_rs, ID_rs,
                              exe_valid_r & ~EXE_load, EXE_wdest,
                              mem_valid_r, MEM_wdest,
                              wb_valid_r, WB_wdest);
    fwd_rt_sel_s = fwd_select(ID_use_rt, ID_rt,
                              exe_valid_r & ~EXE_load, EXE_wdest,
                              mem_valid_r, MEM_wdest,
                              wb_valid_r, WB_wdest);
  end

  // Stage valid bits: flush on reset/cancel, otherwise load from the
  // upstream latch enable whenever the stage accepts new work.
  always_ff @(posedge clk) begin
    if (reset || cancel) begin
      if_valid_r  <= 1'b0;
      id_valid_r  <= 1'b0;
      exe_valid_r <= 1'b0;
      mem_valid_r <= 1'b0;
      wb_valid_r  <= 1'b0;
    end else begin
      if_valid_r <= 1'b1;
      if (id_allow_in_s) begin
        id_valid_r <= if_to_id_s;
      end else begin
        id_valid_r <= id_valid_r;
      end
      if (exe_allow_in_s) begin
        exe_valid_r <= id_to_exe_s;
      end else begin
        exe_valid_r <= exe_valid_r;
      end
      if (mem_allow_in_s) begin
        mem_valid_r <= exe_to_mem_s;
      end else begin
        mem_valid_r <= mem_valid_r;
      end
      if (wb_allow_in_s) begin
        wb_valid_r <= mem_to_wb_s;
      end else begin
        wb_valid_r <= wb_valid_r;
      end
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             any_valid_s;

  assign any_valid_s = if_valid_r | id_valid_r | exe_valid_r |
                       mem_valid_r | wb_valid_r;

  // Performance counters: load-use stall cycles and effective flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (load_use_stall_s) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (cancel && any_valid_s) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

  assign IF_valid       = if_valid_r;
  assign ID_valid       = id_valid_r;
  assign EXE_valid      = exe_valid_r;
  assign MEM_valid      = mem_valid_r;
  assign WB_valid       = wb_valid_r;
  assign next_fetch     = next_fetch_s;
  assign IF_to_ID       = if_to_id_s;
  assign ID_to_EXE      = id_to_exe_s;
  assign EXE_to_MEM     = exe_to_mem_s;
  assign MEM_to_WB      = mem_to_wb_s;
  assign load_use_stall = load_use_stall_s;
  assign fwd_rs_sel     = fwd_rs_sel_s;
  assign fwd_rt_sel     = fwd_rt_sel_s;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed bench for pipeline_ctrl.
// A slot-level pipeline model inside the bench predicts every output each
// cycle; directed phases pin the model with hand-derived literal values.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       IF_over, ID_over, EXE_over, MEM_over, WB_over;
  logic [4:0] ID_rs, ID_rt;
  logic       ID_use_rs, ID_use_rt;
  logic [4:0] EXE_wdest, MEM_wdest, WB_wdest;
  logic       EXE_load;
  logic       cancel;
  logic       IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
  logic       next_fetch;
  logic       IF_to_ID, ID_to_EXE, EXE_to_MEM, MEM_to_WB;
  logic       load_use_stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .IF_over(IF_over), .ID_over(ID_over), .EXE_over(EXE_over),
    .MEM_over(MEM_over), .WB_over(WB_over),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .EXE_wdest(EXE_wdest), .MEM_wdest(MEM_wdest), .WB_wdest(WB_wdest),
    .EXE_load(EXE_load), .cancel(cancel),
    .IF_valid(IF_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
    .MEM_valid(MEM_valid), .WB_valid(WB_valid),
    .next_fetch(next_fetch),
    .IF_to_ID(IF_to_ID), .ID_to_EXE(ID_to_EXE), .EXE_to_MEM(EXE_to_MEM),
    .MEM_to_WB(MEM_to_WB),
    .load_use_stall(load_use_stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_valids();
    return {WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid};
  endfunction

  function automatic logic [3:0] dut_ens();
    return {MEM_to_WB, EXE_to_MEM, ID_to_EXE, IF_to_ID};
  endfunction

  // ---------------- behavioural model ----------------
  // Slots indexed 0=IF .. 4=WB. A slot passes its instruction on when it is
  // finished and the slot ahead is empty or emptying.
  logic [4:0]  m_v = 5'd0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  bit          m_known = 1'b0;

  function automatic logic [1:0] m_fwd(input logic use_op, input logic [4:0] op,
                                       input logic [4:0] v);
    logic [4:0] dest [5];
    dest[2] = EXE_wdest; dest[3] = MEM_wdest; dest[4] = WB_wdest;
    dest[0] = 5'd0; dest[1] = 5'd0;
    if (!use_op) return 2'b00;
    for (int k = 2; k <= 4; k++) begin
      if (v[k] && dest[k] != 5'd0 && dest[k] == op && !(k == 2 && EXE_load))
        return 2'(k - 1);
    end
    return 2'b00;
  endfunction

  initial begin
    logic [4:0] ov, done, outg, free, nv;
    logic [3:0] en;
    logic       stall, go, nf;
    logic [31:0] ns, nfl;
    bit nk;
    forever begin
      @(negedge clk);
      ov = {WB_over, MEM_over, EXE_over, ID_over, IF_over};
      stall = m_v[1] && m_v[2] && EXE_load && EXE_wdest != 5'd0 &&
              ((ID_use_rs && ID_rs == EXE_wdest) || (ID_use_rt && ID_rt == EXE_wdest));
      for (int i = 0; i < 5; i++) done[i] = m_v[i] && ov[i] && !(i == 1 && stall);
      outg[4] = done[4];
      free[4] = !m_v[4] || done[4];
      for (int i = 3; i >= 0; i--) begin
        outg[i] = done[i] && free[i+1];
        free[i] = !m_v[i] || outg[i];
      end
      go = !reset && !cancel;
      for (int i = 0; i < 4; i++) en[i] = outg[i] && go;
      nf = (!m_v[0] && !reset) || en[0];
      if (m_known) begin
        chk("valids", 32'(dut_valids()), 32'(m_v));
        chk("latch_en", 32'(dut_ens()), 32'(en));
        chk("next_fetch", 32'(next_fetch), 32'(nf));
        chk("load_use_stall", 32'(load_use_stall), 32'(stall));
        chk("fwd_rs_sel", 32'(fwd_rs_sel), 32'(m_fwd(ID_use_rs, ID_rs, m_v)));
        chk("fwd_rt_sel", 32'(fwd_rt_sel), 32'(m_fwd(ID_use_rt, ID_rt, m_v)));
        chk("stall_cnt", stall_cnt, PERF ? m_stall : 32'd0);
        chk("flush_cnt", flush_cnt, PERF ? m_flush : 32'd0);
      end
      if (reset || cancel) nv = 5'd0;
      else begin
        nv[0] = 1'b1;
        for (int i = 1; i < 5; i++) nv[i] = free[i] ? en[i-1] : m_v[i];
      end
      if (reset) begin
        ns = 32'd0; nfl = 32'd0;
      end else begin
        ns  = m_stall + (stall ? 32'd1 : 32'd0);
        nfl = m_flush + ((cancel && m_v != 5'd0) ? 32'd1 : 32'd0);
      end
      nk = m_known || reset;
      @(posedge clk);
      m_v = nv; m_stall = ns; m_flush = nfl; m_known = nk;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IF_over = 1'b1; ID_over = 1'b1; EXE_over = 1'b1; MEM_over = 1'b1; WB_over = 1'b1;
    ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    EXE_wdest = 5'd0; MEM_wdest = 5'd0; WB_wdest = 5'd0;
    EXE_load = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset held for three edges.
    repeat (2) tick();
    #3;
    chk("rst_valids", 32'(dut_valids()), 32'd0);
    chk("rst_latch_en", 32'(dut_ens()), 32'd0);
    chk("rst_next_fetch", 32'(next_fetch), 32'd0);
    tick();
    reset = 1'b0;
    #3;
    chk("post_rst_next_fetch", 32'(next_fetch), 32'd1);
    chk("post_rst_if_valid", 32'(IF_valid), 32'd0);

    // Fill: WB_valid first high five cycles after release.
    repeat (4) tick();
    #3;
    chk("fill_wb_c4", 32'(WB_valid), 32'd0);
    tick();
    #3;
    chk("fill_wb_c5", 32'(WB_valid), 32'd1);
    chk("flow_en_c5", 32'(dut_ens()), 32'hF);
    chk("flow_nf_c5", 32'(next_fetch), 32'd1);
    tick();
    #3;
    chk("flow_valids", 32'(dut_valids()), 32'h1F);
    chk("flow_en_c6", 32'(dut_ens()), 32'hF);

    // Load-use: lw $3 in EXE, ID reads $3.
    tick();
    EXE_wdest = 5'd3; EXE_load = 1'b1; ID_rs = 5'd3; ID_use_rs = 1'b1;
    #3;
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    chk("lu_id_to_exe", 32'(ID_to_EXE), 32'd0);
    tick();
    EXE_wdest = 5'd0; EXE_load = 1'b0; MEM_wdest = 5'd3;
    #3;
    chk("lu_bubble", 32'(EXE_valid), 32'd0);
    chk("lu_stall_end", 32'(load_use_stall), 32'd0);
    chk("lu_fwd_mem", 32'(fwd_rs_sel), 32'd2);
    MEM_wdest = 5'd0; ID_rs = 5'd0; ID_use_rs = 1'b0;
    repeat (4) tick();

    // Forwarding priority on rt = $17.
    EXE_wdest = 5'd17; MEM_wdest = 5'd17; WB_wdest = 5'd17;
    ID_rt = 5'd17; ID_use_rt = 1'b1;
    #3;
    chk("fw_full_valids", 32'(dut_valids()), 32'h1F);
    chk("fw_exe", 32'(fwd_rt_sel), 32'd1);
    ID_over = 1'b0;
    tick();
    #3;
    chk("fw_exe_empty", 32'(EXE_valid), 32'd0);
    chk("fw_mem", 32'(fwd_rt_sel), 32'd2);
    tick();
    #3;
    chk("fw_mem_empty", 32'({MEM_valid, EXE_valid}), 32'd0);
    chk("fw_wb", 32'(fwd_rt_sel), 32'd3);
    ID_rt = 5'd0;
    #1;
    chk("fw_zero", 32'(fwd_rt_sel), 32'd0);
    idle_inputs();
    repeat (4) tick();

    // WB back-pressure for four cycles.
    WB_over = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #3;
      chk("bp_en", 32'(dut_ens()), 32'd0);
      chk("bp_nf", 32'(next_fetch), 32'd0);
      chk("bp_valids", 32'(dut_valids()), 32'h1F);
      tick();
    end
    WB_over = 1'b1;
    #3;
    chk("bp_resume_en", 32'(dut_ens()), 32'hF);
    chk("bp_resume_nf", 32'(next_fetch), 32'd1);

    // Single-cycle cancel in a full pipe.
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    #3;
    chk("cx_valids", 32'(dut_valids()), 32'd0);
    chk("cx_nf", 32'(next_fetch), 32'd1);
    tick();
    #3;
    chk("cx_refetch", 32'(dut_valids()), 32'd1);
    chk("cx_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("cx_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset     = ($urandom_range(0, 99) == 0);
      cancel    = ($urandom_range(0, 31) == 0);
      IF_over   = ($urandom_range(0, 3) != 0);
      ID_over   = ($urandom_range(0, 3) != 0);
      EXE_over  = ($urandom_range(0, 3) != 0);
      MEM_over  = ($urandom_range(0, 3) != 0);
      WB_over   = ($urandom_range(0, 3) != 0);
      ID_rs     = 5'($urandom_range(0, 3));
      ID_rt     = 5'($urandom_range(0, 3));
      ID_use_rs = 1'($urandom_range(0, 1));
      ID_use_rt = 1'($urandom_range(0, 1));
      EXE_wdest = 5'($urandom_range(0, 3));
      MEM_wdest = 5'($urandom_range(0, 3));
      WB_wdest  = 5'($urandom_range(0, 3));
      EXE_load  = ($urandom_range(0, 2) == 0);
    end
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stage-sequencing and hazard controller for the 5-stage pipeline_cpu (IF/ID/EXE/MEM/WB).
- Owns the per-stage valid bits and the allow-in/over handshake between stages.
- Generates latch enables for the IF_ID, ID_EXE, EXE_MEM and MEM_WB pipeline registers, detects load-use hazards, and selects forwarding sources for ID operands.
- Also flushes the pipeline on a WB-stage cancel (exception/eret).

Parameters:
- REG_AW, 5: register address width.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IF_over  in  1  fetch in IF completes this cycle
- ID_over  in  1  ID work completes this cycle
- EXE_over  in  1  EXE work completes this cycle (low during multi-cycle mult/div)
- MEM_over  in  1  MEM work completes this cycle
- WB_over  in  1  WB work completes this cycle
- ID_rs  in  REG_AW  ID source register 1
- ID_rt  in  REG_AW  ID source register 2
- ID_use_rs  in  1  ID instruction reads rs
- ID_use_rt  in  1  ID instruction reads rt
- EXE_wdest  in  REG_AW  EXE-stage destination register (0 = no write)
- MEM_wdest  in  REG_AW  MEM-stage destination register (0 = no write)
- WB_wdest  in  REG_AW  WB-stage destination register (0 = no write)
- EXE_load  in  1  EXE instruction is lw
- cancel  in  1  flush request from WB
- IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid  out  1 each  stage holds a live instruction
- next_fetch  out  1  PC register loads the next fetch address
- IF_to_ID, ID_to_EXE, EXE_to_MEM, MEM_to_WB  out  1 each  pipeline-register latch enables
- load_use_stall  out  1  ID is held due to a load-use hazard
- fwd_rs_sel  out  2  rs operand source: 00 regfile, 01 EXE, 10 MEM, 11 WB
- fwd_rt_sel  out  2  rt operand source, same encoding
- stall_cnt  out  CNT_W  load-use stall cycle count
- flush_cnt  out  CNT_W  cancel event count

Behaviour:
- Reset (sync, active-high): all five valid bits = 0; counters = 0. All combinational outputs derive from these.
- Qualified completion:
  - Xq = X_valid & X_over for each stage.
  - IDq is additionally gated by !load_use_stall.
- Allow-in:
  - WB_allow_in = !WB_valid | WB_over.
  - For X in {MEM, EXE, ID}: X_allow_in = !X_valid | (Xq & next_stage_allow_in).
- Latch enables:
  - IF_to_ID = IFq & ID_allow_in.
  - ID_to_EXE = IDq & EXE_allow_in.
  - EXE_to_MEM = EXEq & MEM_allow_in.
  - MEM_to_WB = MEMq & WB_allow_in.
- Valid update for Y in {ID..WB}, each clk, with X the preceding stage:
  - If cancel: Y_valid <= 0.
  - Else if Y_allow_in: Y_valid <= X_to_Y.
  - Else: Y_valid holds.
- IF sequencing:
  - IF_valid <= 0 on reset or cancel; otherwise IF_valid <= 1.
  - Consequence: IF is empty exactly one cycle after reset release and after each cancel.
  - next_fetch = (!IF_valid & !reset) | IF_to_ID; PC update and cancel-vector selection are external.
- Load-use:
  - load_use_stall = ID_valid & EXE_valid & EXE_load & (EXE_wdest != 0) & ((ID_use_rs & ID_rs == EXE_wdest) | (ID_use_rt & ID_rt == EXE_wdest)).
  - While asserted: ID holds and a bubble enters EXE.
  - Lasts exactly 1 cycle when MEM accepts the load immediately.
- Forwarding, per operand, priority EXE > MEM > WB:
  - EXE matches only if EXE_valid, !EXE_load, dest != 0, and dest equals the operand.
  - MEM and WB match on valid, dest != 0, and dest equals the operand.
  - No match, or use bit low -> 00.
  - A stage's match suppresses all lower-priority matches.
- Simultaneous events:
  - cancel overrides every transfer and stall in the same cycle.
  - Backpressure from WB ripples to IF combinationally in the same cycle; no instruction is duplicated or lost.
- Reset mid-operation: all in-flight valids are dropped; no latch enables are asserted during reset.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments each cycle load_use_stall = 1.
  - flush_cnt increments on each cycle cancel = 1 while any valid bit = 1.
  - Both counters wrap modulo 2^CNT_W and clear on reset.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset held 3 cycles, then released:
  - All valids = 0 during reset; next_fetch = 1 on the first post-reset cycle.
  - With all *_over = 1, WB_valid first rises 5 cycles after reset release.
- Free flow, all *_over = 1, no hazards:
  - Every latch enable = 1 each cycle after fill; one instruction retires per clk.
- lw $3 in EXE (EXE_wdest = 3, EXE_load = 1), ID_rs = 3, ID_use_rs = 1:
  - load_use_stall = 1 and ID_to_EXE = 0 for 1 cycle; EXE_valid = 0 next cycle.
  - Following cycle: fwd_rs_sel = 10.
- EXE_wdest = MEM_wdest = WB_wdest = 17, all valid, ID_rt = 17, ID_use_rt = 1, EXE_load = 0:
  - fwd_rt_sel = 01.
  - Drop EXE_valid -> 10; also drop MEM_valid -> 11.
  - Set ID_rt = 0 -> 00.
- WB_over = 0 for 4 cycles in a full pipe:
  - All latch enables = 0; valids hold; PC does not advance (next_fetch = 0).
  - Resumes with no lost or duplicated instruction.
- cancel = 1 for one cycle in a full pipe:
  - All valids = 0 next cycle, then IF_valid = 1 the cycle after.
  - With PIPELINE_CTRL_PERF_EN: flush_cnt = 1.
